// File: rtl/motion_pkg.sv
// Shared constants for the gantry motion controller.
// Command modes, status codes, FSM states, coil phase table.
package motion_pkg;

  localparam logic MODE_MOVE = 1'b0;
  localparam logic MODE_HOME = 1'b1;

  localparam logic [1:0] ST_OK         = 2'd0;
  localparam logic [1:0] ST_LIMIT      = 2'd1;
  localparam logic [1:0] ST_ABORT      = 2'd2;
  localparam logic [1:0] ST_HOME_FAULT = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_HOME,
    S_FINISH
  } state_t;

  // Coil order is red, blue, yellow, orange (MSB first).
  function automatic logic [3:0] phase_of(input logic [1:0] idx);
    logic [3:0] ph;
    unique case (idx)
      2'd0: ph = 4'b1000;
      2'd1: ph = 4'b0100;
      2'd2: ph = 4'b0010;
      default: ph = 4'b0001;
    endcase
    return ph;
  endfunction

endpackage

// File: rtl/stepper_axis.sv
// One stepper axis: phase index, absolute position, MOVE/HOME stepping.
// Ports: i_tick step strobe, i_start latch command, i_dir/i_steps/i_home
// command fields, i_abort stop, i_lim_lo/i_lim_hi switches; o_phase coils,
// o_pos position, o_active stepping, o_hit_limit, o_fault home timeout.
module stepper_axis
  import motion_pkg::*;
#(
  parameter int STEP_W      = 12,
  parameter int POS_W       = 16,
  parameter int HOME_MAX    = 4095,
  parameter int HOLD_TORQUE = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_tick,
  input  logic              i_start,
  input  logic              i_dir,
  input  logic [STEP_W-1:0] i_steps,
  input  logic              i_home,
  input  logic              i_abort,
  input  logic              i_lim_lo,
  input  logic              i_lim_hi,
  output logic [3:0]        o_phase,
  output logic [POS_W-1:0]  o_pos,
  output logic              o_active,
  output logic              o_hit_limit,
  output logic              o_fault
);

  localparam int HC_RAW = $clog2(HOME_MAX + 1);
  localparam int HC_W   = (HC_RAW > STEP_W) ? HC_RAW : STEP_W;

  logic              r_active;
  logic              r_dir;
  logic              r_home;
  logic              r_energ;
  logic              r_hit;
  logic              r_fault;
  logic [1:0]        r_idx;
  logic [POS_W-1:0]  r_pos;
  logic [STEP_W-1:0] r_rem;
  logic [HC_W-1:0]   r_cnt;

  logic              w_go;
  logic              w_lim;
  logic [1:0]        w_idx;
  logic [POS_W-1:0]  w_pos;

  assign w_go  = i_home | (|i_steps);
  assign w_lim = r_dir ? i_lim_hi : i_lim_lo;
  assign w_idx = r_dir ? r_idx + 2'd1 : r_idx - 2'd1;
  assign w_pos = r_dir ? r_pos + POS_W'(1)
                       : r_pos - POS_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_active <= 1'b0;
      r_dir    <= 1'b0;
      r_home   <= 1'b0;
      r_energ  <= 1'b0;
      r_hit    <= 1'b0;
      r_fault  <= 1'b0;
      r_idx    <= 2'd0;
      r_pos    <= '0;
      r_rem    <= '0;
      r_cnt    <= '0;
    end else if (i_start) begin
      r_active <= w_go;
      r_dir    <= i_dir & ~i_home;
      r_home   <= i_home;
      r_rem    <= i_steps;
      r_cnt    <= '0;
      r_hit    <= 1'b0;
      r_fault  <= 1'b0;
      if (w_go) r_energ <= 1'b1;
    end else if (i_abort) begin
      r_active <= 1'b0;
    end else if (i_tick && r_active) begin
      if (w_lim) begin
        // Home dir is always 0, so w_lim is limit_lo there.
        r_active <= 1'b0;
        if (r_home) r_pos <= '0;
        else        r_hit <= 1'b1;
      end else begin
        r_idx <= w_idx;
        r_pos <= w_pos;
        if (r_home) begin
          r_cnt <= r_cnt + HC_W'(1);
          if (r_cnt == HC_W'(HOME_MAX - 1)) begin
            r_active <= 1'b0;
            r_fault  <= 1'b1;
          end
        end else begin
          r_rem <= r_rem - STEP_W'(1);
          if (r_rem == STEP_W'(1)) r_active <= 1'b0;
        end
      end
    end
  end

  assign o_phase = (r_active || (HOLD_TORQUE != 0 && r_energ))
                 ? phase_of(r_idx) : 4'b0000;
  assign o_pos       = r_pos;
  assign o_active    = r_active;
  assign o_hit_limit = r_hit;
  assign o_fault     = r_fault;

endmodule

// File: rtl/gantry_motion_ctrl.sv
// N-axis gantry stepper controller: handshake, step divider, FSM, status.
// Ports: cmd_* command channel and abort, limit_lo/hi switches,
// coils/pos per axis, busy, done pulse, status code.
module gantry_motion_ctrl
  import motion_pkg::*;
#(
  parameter int NUM_AXES    = 2,
  parameter int STEP_W      = 12,
  parameter int POS_W       = 16,
  parameter int DIV_W       = 20,
  parameter int STEP_DIV    = 50000,
  parameter int HOME_MAX    = 4095,
  parameter int HOLD_TORQUE = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd_mode,
  input  logic [NUM_AXES-1:0]        cmd_dir,
  input  logic [NUM_AXES*STEP_W-1:0] cmd_steps,
  input  logic                       cmd_abort,
  input  logic [NUM_AXES-1:0]        limit_lo,
  input  logic [NUM_AXES-1:0]        limit_hi,
  output logic [4*NUM_AXES-1:0]      coils,
  output logic [NUM_AXES*POS_W-1:0]  pos,
  output logic                       busy,
  output logic                       done,
  output logic [1:0]                 status
);

  state_t             r_state;
  state_t             w_next;
  logic [DIV_W-1:0]   r_div;
  logic [1:0]         r_status;
  logic [1:0]         w_fin;
  logic [NUM_AXES-1:0] w_active;
  logic [NUM_AXES-1:0] w_hit;
  logic [NUM_AXES-1:0] w_fault;
  logic               w_run;
  logic               w_accept;
  logic               w_abort;
  logic               w_tick;
  logic               w_home;
  logic               w_wrap;

  assign w_run    = (r_state == S_RUN) || (r_state == S_HOME);
  assign cmd_ready = (r_state == S_IDLE) || (r_state == S_FINISH);
  assign w_accept = cmd_valid & cmd_ready;
  assign w_abort  = w_run & cmd_abort;
  assign w_wrap   = (r_div == DIV_W'(STEP_DIV - 1));
  // Abort wins over a tick landing in the same cycle.
  assign w_tick   = w_run & ~cmd_abort & w_wrap;
  assign w_home   = (cmd_mode == MODE_HOME);

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE, S_FINISH: begin
        if (w_accept) w_next = w_home ? S_HOME : S_RUN;
        else          w_next = S_IDLE;
      end
      S_RUN, S_HOME: begin
        if (w_abort || !(|w_active)) w_next = S_FINISH;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_fin = ST_OK;
    if (w_abort)       w_fin = ST_ABORT;
    else if (|w_fault) w_fin = ST_HOME_FAULT;
    else if (|w_hit)   w_fin = ST_LIMIT;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_status <= ST_OK;
      r_div    <= '0;
    end else begin
      if (w_accept) r_status <= ST_OK;
      else if (w_run && w_next == S_FINISH) r_status <= w_fin;
      if (w_accept)   r_div <= '0;
      else if (w_run) r_div <= w_wrap ? '0 : r_div + DIV_W'(1);
    end
  end

  for (genvar g = 0; g < NUM_AXES; g++) begin : g_axis
    stepper_axis #(
      .STEP_W      (STEP_W),
      .POS_W       (POS_W),
      .HOME_MAX    (HOME_MAX),
      .HOLD_TORQUE (HOLD_TORQUE)
    ) u_axis (
      .clk         (clk),
      .reset       (reset),
      .i_tick      (w_tick),
      .i_start     (w_accept),
      .i_dir       (cmd_dir[g]),
      .i_steps     (cmd_steps[g*STEP_W +: STEP_W]),
      .i_home      (w_home),
      .i_abort     (w_abort),
      .i_lim_lo    (limit_lo[g]),
      .i_lim_hi    (limit_hi[g]),
      .o_phase     (coils[4*g +: 4]),
      .o_pos       (pos[g*POS_W +: POS_W]),
      .o_active    (w_active[g]),
      .o_hit_limit (w_hit[g]),
      .o_fault     (w_fault[g])
    );
  end

  assign busy   = w_run;
  assign done   = (r_state == S_FINISH);
  assign status = r_status;

endmodule

// File: tb/tb_gantry_motion_ctrl.sv
// Self-checking bench for gantry_motion_ctrl.
// Table of steady-limit commands plus hand sequences for corner cases.
module tb_gantry_motion_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_mode;
  logic [1:0]  cmd_dir;
  logic [23:0] cmd_steps;
  logic        cmd_abort;
  logic [1:0]  limit_lo;
  logic [1:0]  limit_hi;
  logic [7:0]  coils;
  logic [31:0] pos;
  logic        busy;
  logic        done;
  logic [1:0]  status;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  gantry_motion_ctrl #(
    .NUM_AXES(2), .STEP_W(12), .POS_W(16), .DIV_W(20),
    .STEP_DIV(4), .HOME_MAX(16), .HOLD_TORQUE(1)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_mode(cmd_mode), .cmd_dir(cmd_dir),
    .cmd_steps(cmd_steps), .cmd_abort(cmd_abort),
    .limit_lo(limit_lo), .limit_hi(limit_hi),
    .coils(coils), .pos(pos), .busy(busy),
    .done(done), .status(status)
  );

  typedef struct {
    logic        mode;
    logic [1:0]  dir;
    logic [11:0] s0;
    logic [11:0] s1;
    logic [1:0]  lo;
    logic [1:0]  hi;
    int          lat;
    logic [1:0]  st;
    logic [15:0] p0;
    logic [15:0] p1;
    logic [7:0]  co;
  } vec_t;

  vec_t vt [5];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic issue(input logic m, input logic [1:0] d,
                       input logic [11:0] s0, input logic [11:0] s1);
    cmd_mode  = m;
    cmd_dir   = d;
    cmd_steps = {s1, s0};
    cmd_valid = 1'b1;
    chk("ready_at_issue", {31'd0, cmd_ready}, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int maxc,
                           output int lat);
    lat = 0;
    while (!done && lat < maxc) begin
      @(negedge clk);
      lat++;
    end
    chk({nm, "_done_seen"}, {31'd0, done}, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int lat;
    logic saw;

    vt[0] = '{mode:1'b0, dir:2'b00, s0:12'd0, s1:12'd0,
              lo:2'b00, hi:2'b00, lat:1, st:2'd0,
              p0:16'h0003, p1:16'hFFFE, co:8'h21};
    vt[1] = '{mode:1'b0, dir:2'b10, s0:12'd1, s1:12'd4,
              lo:2'b00, hi:2'b00, lat:17, st:2'd0,
              p0:16'h0002, p1:16'h0002, co:8'h22};
    vt[2] = '{mode:1'b0, dir:2'b01, s0:12'd2, s1:12'd1,
              lo:2'b00, hi:2'b01, lat:5, st:2'd1,
              p0:16'h0002, p1:16'h0001, co:8'h42};
    vt[3] = '{mode:1'b1, dir:2'b11, s0:12'd9, s1:12'd9,
              lo:2'b11, hi:2'b00, lat:5, st:2'd0,
              p0:16'h0000, p1:16'h0000, co:8'h42};
    vt[4] = '{mode:1'b0, dir:2'b00, s0:12'd1, s1:12'd1,
              lo:2'b10, hi:2'b00, lat:5, st:2'd1,
              p0:16'hFFFF, p1:16'h0000, co:8'h44};

    reset = 1'b1;
    cmd_valid = 1'b0;
    cmd_mode = 1'b0;
    cmd_dir = 2'b00;
    cmd_steps = '0;
    cmd_abort = 1'b0;
    limit_lo = 2'b00;
    limit_hi = 2'b00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_ready", {31'd0, cmd_ready}, 1);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_status", {30'd0, status}, 0);
    chk("rst_pos", pos, 0);
    chk("rst_coils", {24'd0, coils}, 0);

    // Coil sequence on axis 0 while moving 3 up / 2 down.
    issue(1'b0, 2'b01, 12'd3, 12'd2);
    chk("h1_busy", {31'd0, busy}, 1);
    chk("h1_ready", {31'd0, cmd_ready}, 0);
    n = 0;
    while (!done && n < 100) begin
      if (n == 0 || n == 4 || n == 8 || n == 12)
        chk($sformatf("h1_coil0_n%0d", n),
            {28'd0, coils[3:0]}, 32'h8 >> (n / 4));
      @(negedge clk);
      n++;
    end
    chk("h1_done_seen", {31'd0, done}, 1);
    chk("h1_lat", n, 13);
    chk("h1_status", {30'd0, status}, 0);
    chk("h1_pos0", {16'd0, pos[15:0]}, 32'h0003);
    chk("h1_pos1", {16'd0, pos[31:16]}, 32'hFFFE);
    chk("h1_busy_done", {31'd0, busy}, 0);
    @(negedge clk);
    chk("h1_done_pulse", {31'd0, done}, 0);

    for (int i = 0; i < 5; i++) begin
      limit_lo = vt[i].lo;
      limit_hi = vt[i].hi;
      issue(vt[i].mode, vt[i].dir, vt[i].s0, vt[i].s1);
      wait_done($sformatf("v%0d", i), 200, lat);
      chk($sformatf("v%0d_lat", i), lat, vt[i].lat);
      chk($sformatf("v%0d_status", i), {30'd0, status},
          {30'd0, vt[i].st});
      chk($sformatf("v%0d_pos0", i), {16'd0, pos[15:0]},
          {16'd0, vt[i].p0});
      chk($sformatf("v%0d_pos1", i), {16'd0, pos[31:16]},
          {16'd0, vt[i].p1});
      chk($sformatf("v%0d_coils", i), {24'd0, coils},
          {24'd0, vt[i].co});
      @(negedge clk);
      limit_lo = 2'b00;
      limit_hi = 2'b00;
    end

    // limit_hi[0] rises before tick 3 of a 5-step move.
    issue(1'b0, 2'b01, 12'd5, 12'd0);
    n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
      if (n == 10) limit_hi = 2'b01;
    end
    chk("h2_done_seen", {31'd0, done}, 1);
    chk("h2_lat", n, 13);
    chk("h2_status", {30'd0, status}, 1);
    chk("h2_pos0", {16'd0, pos[15:0]}, 32'h0001);
    chk("h2_pos1", {16'd0, pos[31:16]}, 32'h0000);
    chk("h2_coils", {24'd0, coils}, 32'h41);
    @(negedge clk);
    limit_hi = 2'b00;

    // Home: axis1 switch stuck, axis0 switch rises after tick 4.
    limit_lo = 2'b10;
    issue(1'b1, 2'b11, 12'd7, 12'd7);
    n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
      if (n == 17) limit_lo = 2'b11;
    end
    chk("h3_done_seen", {31'd0, done}, 1);
    chk("h3_lat", n, 21);
    chk("h3_status", {30'd0, status}, 0);
    chk("h3_pos", pos, 0);
    @(negedge clk);
    limit_lo = 2'b00;

    issue(1'b1, 2'b00, 12'd0, 12'd0);
    wait_done("h3b", 150, lat);
    chk("h3b_lat", lat, 65);
    chk("h3b_status", {30'd0, status}, 3);
    chk("h3b_pos", pos, 32'hFFF0_FFF0);
    @(negedge clk);

    // Abort in idle does nothing.
    cmd_abort = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_abort_busy", {31'd0, busy}, 0);
    chk("idle_abort_done", {31'd0, done}, 0);
    cmd_abort = 1'b0;

    // Abort during the tick-4 cycle.
    issue(1'b0, 2'b01, 12'd10, 12'd0);
    n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
      if (n == 15) cmd_abort = 1'b1;
    end
    chk("h4_done_seen", {31'd0, done}, 1);
    chk("h4_lat", n, 16);
    chk("h4_status", {30'd0, status}, 2);
    chk("h4_ready", {31'd0, cmd_ready}, 1);
    chk("h4_pos0", {16'd0, pos[15:0]}, 32'hFFF3);
    chk("h4_pos1", {16'd0, pos[31:16]}, 32'hFFF0);
    cmd_abort = 1'b0;
    @(negedge clk);

    // Reset in the middle of a move.
    issue(1'b0, 2'b11, 12'd10, 12'd10);
    repeat (6) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("h5_coils", {24'd0, coils}, 0);
    chk("h5_pos", pos, 0);
    chk("h5_busy", {31'd0, busy}, 0);
    chk("h5_done", {31'd0, done}, 0);
    chk("h5_ready", {31'd0, cmd_ready}, 1);
    reset = 1'b0;
    saw = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (done) saw = 1'b1;
    end
    chk("h5_no_done", {31'd0, saw}, 0);

    // Back-to-back: second command held valid across done.
    issue(1'b0, 2'b01, 12'd1, 12'd0);
    n = 0;
    while (!done && n < 50) begin
      @(negedge clk);
      n++;
      if (n == 2) begin
        cmd_dir   = 2'b01;
        cmd_steps = {12'd0, 12'd2};
        cmd_valid = 1'b1;
      end
    end
    chk("h6_done_seen", {31'd0, done}, 1);
    chk("h6_lat", n, 5);
    chk("h6_ready_at_done", {31'd0, cmd_ready}, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("h6_busy_next", {31'd0, busy}, 1);
    chk("h6_ready_next", {31'd0, cmd_ready}, 0);
    wait_done("h6b", 50, lat);
    chk("h6b_lat", lat, 9);
    chk("h6b_status", {30'd0, status}, 0);
    chk("h6b_pos0", {16'd0, pos[15:0]}, 32'h0003);
    @(negedge clk);
    chk("h6_idle_after", {31'd0, busy}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gantry_motion_ctrl.md
Name: gantry_motion_ctrl

Overview:
Parametrised N-axis stepper motion controller for the gantry, generalising the two-motor bar/magnet driver. It accepts one motion command per valid/ready handshake and drives all axes concurrently with independent step counts and directions. It supports MOVE and HOME modes, tracks an absolute position per axis, and handles abort. It reports completion as a one-cycle done pulse plus a status code, replacing the level-held per-type done flags.

Parameters:
NUM_AXES, 2, number of stepper axes
STEP_W, 12, width of per-axis step count in a command
POS_W, 16, width of per-axis absolute position counter (two's complement)
DIV_W, 20, width of step-rate divider
STEP_DIV, 50000, clk cycles per motor step (>=2)
HOME_MAX, 4095, maximum steps per axis during HOME before fault
HOLD_TORQUE, 1, 1 = coils hold last phase when idle; 0 = coils driven 0000 when idle

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
cmd_valid  in  1  command offered
cmd_ready  out  1  controller can accept command
cmd_mode  in  1  0 = MOVE, 1 = HOME
cmd_dir  in  NUM_AXES  per-axis direction, 1 = positive (south/east), 0 = negative
cmd_steps  in  NUM_AXES*STEP_W  per-axis step count, axis i at [i*STEP_W +: STEP_W]
cmd_abort  in  1  level; stops motion in progress
limit_lo  in  NUM_AXES  negative-end limit switch, active-high
limit_hi  in  NUM_AXES  positive-end limit switch, active-high
coils  out  4*NUM_AXES  coil drive for axis i at [4*i +: 4], order red, blue, yellow, orange
pos  out  NUM_AXES*POS_W  absolute position per axis
busy  out  1  command in progress
done  out  1  one-cycle completion pulse
status  out  2  valid while done is high and held until next accept: 0 OK, 1 LIMIT, 2 ABORT, 3 HOME_FAULT

Behaviour:
- Reset values: cmd_ready=1, busy=0, done=0, status=0, pos=0, coils=0000 per axis, phase index 0, FSM IDLE. Reset mid-operation aborts immediately, with no done pulse.
- FSM states:
  - IDLE: cmd_ready=1. On cmd_valid && cmd_ready (edge t0), latch the command, go to RUN (MOVE) or HOME, and set busy=1 and cmd_ready=0 from t0+1.
  - RUN/HOME: all axes active concurrently.
  - FINISH: done=1 for one cycle, busy=0, cmd_ready=1, status updated, then IDLE. A new command may be accepted on the cycle after done.
- The shared divider clears at accept. A step tick occurs every STEP_DIV cycles, so the k-th tick is at t0 + k*STEP_DIV.
- Phase sequence per axis:
  - Phases are 1000, 0100, 0010, 0001.
  - dir=1 advances the index and dir=0 retreats it, both mod 4.
  - pos increments for dir=1 and decrements for dir=0, mod 2^POS_W.
- MOVE:
  - An axis with steps=0 is inactive from the start.
  - On each tick, an active axis with remaining>0 checks the limit switch in its travel direction (limit_hi for dir=1, limit_lo for dir=0).
  - If that limit is asserted, the step is suppressed, the axis stops, and a LIMIT flag is set.
  - Otherwise it steps and decrements remaining.
  - Go to FINISH on the cycle after the last active axis stops.
  - Latency: all axes n steps with no limit → done at t0 + n*STEP_DIV + 1.
  - All axes zero → done at t0 + 1, status OK.
  - Final status is LIMIT if any axis hit a limit, else OK.
- HOME:
  - cmd_dir and cmd_steps are ignored. Every axis moves dir=0 until limit_lo is seen at a tick.
  - An axis whose limit_lo is already high at its first tick takes zero steps.
  - When an axis stops on limit_lo, its pos is set to 0.
  - If an axis reaches HOME_MAX steps without limit_lo, it stops, pos is left unchanged, and status is HOME_FAULT.
  - Otherwise status is OK.
- Abort:
  - cmd_abort high in RUN/HOME at any cycle → FINISH next cycle with status ABORT.
  - A step tick in the same cycle as abort is suppressed (abort has priority).
  - pos reflects the steps already taken.
  - cmd_abort in IDLE is ignored.
- Status priority on the same finish: ABORT > HOME_FAULT > LIMIT > OK.
- Coils:
  - Active axis: drive its current phase.
  - Idle axis: phase if HOLD_TORQUE=1, else 0000.
  - An axis that is not stepping in a command keeps the same rule as idle.
- Width rules:
  - remaining is STEP_W wide.
  - The HOME step counter is wide enough for HOME_MAX (>= STEP_W).
  - Divider compare is against STEP_DIV-1.

Decomposition:
- Package motion_pkg: mode constants (MODE_MOVE, MODE_HOME), status codes (ST_OK, ST_LIMIT, ST_ABORT, ST_HOME_FAULT), FSM state encoding, and the phase table.
- Sub-module stepper_axis, instantiated NUM_AXES times via generate.
  - Inputs: tick, start, dir, steps, home, abort, limits.
  - Outputs: phase, pos, active, hit_limit, fault.
  - The top level holds the divider, FSM, handshake and status.

Test Plan (STEP_DIV=4, HOME_MAX=16, HOLD_TORQUE=1):
- MOVE dir=1/0, steps=3/2 from reset → coils axis0 1000→0100→0010→0001; pos0=3, pos1=-2 (0xFFFE); done at t0+13, status OK.
- MOVE steps=0/0 → done at t0+1, status OK, coils unchanged, pos unchanged.
- MOVE axis0 dir=1 steps=5 with limit_hi[0] raised before tick 3 → exactly 2 steps, pos0=2, done at t0+13, status LIMIT.
- HOME with limit_lo[0] raised after 4 ticks and limit_lo[1] stuck high → axis1 0 steps; both pos=0; status OK. A second HOME with no limits → 16 steps each, status HOME_FAULT.
- MOVE steps=10, cmd_abort asserted at the cycle of tick 4 → 3 steps taken, pos0=3, done next cycle, status ABORT; cmd_ready=1 the same cycle.
- reset asserted mid-MOVE → next cycle coils=0, pos=0, busy=0, no done. Back-to-back: a command held valid across done is accepted on the cycle after done.
